rc5_crypt: RTL and testbench

Parametrised RC5-W/R datapath performing block encryption and, optionally, decryption. It sits between the key-schedule RAM, which holds the expanded table S[0..2R+1], and the block-level controller. A single start pulse launches one block. The block reads two table words per round over a synchronous-read port and returns the result with a one-cycle done pulse. It supersedes the encrypt-only cipher by adding a pulse handshake, a busy flag, a selectable direction and generic W/R.

---
 rtl/rc5_crypt.sv | 193 +++++++++++++++++++
 tb/tb_rc5_crypt.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_crypt.sv
`default_nettype none
// ============================================================================
// Module   : rc5_crypt
// Purpose  : RC5-W/R block datapath. One iStart pulse processes one block
//            (encrypt, or decrypt when built with RC5_DECRYPT_EN) using the
//            expanded key table S[0..2R+1] read through a synchronous-read
//            port. Each round index k costs four cycles
//            (ADDR, WAIT, HALF1, HALF2), followed by a one-cycle DONE pulse.
// Config   : RC5_DECRYPT_EN - when defined, iMode selects the direction and
//            the subtract / right-rotate / descending-k logic is built.
//            When undefined, iMode is ignored and every block encrypts.
// Ports    : clk, rst             clock, synchronous active-high reset
//            iStart, iMode        start pulse (IDLE only), direction
//            iA, iB               input block words, sampled with iStart
//            oS_address1/2        registered key-table addresses (2k, 2k+1)
//            iS_sub_i1/2          key-table data for those addresses
//            oA, oB               result words (registered)
//            oBusy, oDone         busy flag, one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module rc5_crypt #(
  parameter int W         = 32,
  parameter int R         = 12,
  parameter int T_LENGTH  = $clog2(2*(R+1)),
  parameter int ROT_VALUE = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic                iMode,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [T_LENGTH-1:0] oS_address1,
  output logic [T_LENGTH-1:0] oS_address2,
  input  logic [W-1:0]        iS_sub_i1,
  input  logic [W-1:0]        iS_sub_i2,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  output logic                oBusy,
  output logic                oDone
);

  // k spans 0..R; the table address is simply {k, half-select bit}.
  localparam int             K_W    = T_LENGTH - 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(R);
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HALF1 = 3'd3,
    ST_HALF2 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t         state;
  logic [W-1:0]   a_word;
  logic [W-1:0]   b_word;
  logic [K_W-1:0] k;

  logic           sel_b;        // this half-round updates B (else A)
  logic           whiten;       // k == 0: add/sub only, no rotate/xor
  logic [W-1:0]   x_word;       // word being updated
  logic [W-1:0]   y_word;       // the other word (xor / rotate control)
  logic [W-1:0]   s_word;       // key word paired with x_word
  logic [W-1:0]   rot_in;
  logic [W-1:0]   rot_out;
  logic [W-1:0]   half_result;
  logic [ROT_VALUE-1:0] rot_amt;
  logic [ROT_VALUE-1:0] rot_left_amt;
  logic [K_W-1:0] k_start;
  logic [K_W-1:0] k_step;
  logic           k_last;

  assign whiten  = (k == '0);
  assign rot_amt = whiten ? '0 : y_word[ROT_VALUE-1:0];

`ifdef RC5_DECRYPT_EN
  logic dec_mode;

  // Encrypt updates A then B; decrypt updates B then A.
  assign sel_b   = (state == ST_HALF2) ^ dec_mode;
  assign k_start = iMode ? K_LAST : '0;
  assign k_step  = dec_mode ? (k - K_ONE) : (k + K_ONE);
  assign k_last  = dec_mode ? (k == '0) : (k == K_LAST);

  // Encrypt: rotl(x ^ y, y) + s.  Decrypt: rotr(x - s, y) ^ y.
  // During whitening the rotate amount and xor operand collapse to zero.
  always_comb begin
    rot_in      = whiten ? x_word : (x_word ^ y_word);
    half_result = rot_out + s_word;
    if (dec_mode) begin
      rot_in      = x_word - s_word;
      half_result = rot_out ^ (whiten ? '0 : y_word);
    end
  end

  // Right rotate by n equals left rotate by (W - n) mod W.
  assign rot_left_amt = dec_mode ? -rot_amt : rot_amt;
`else
  logic unused_mode;
  assign unused_mode = iMode;

  assign sel_b        = (state == ST_HALF2);
  assign k_start      = '0;
  assign k_step       = k + K_ONE;
  assign k_last       = (k == K_LAST);
  assign rot_in       = whiten ? x_word : (x_word ^ y_word);
  assign half_result  = rot_out + s_word;
  assign rot_left_amt = rot_amt;
`endif

  assign x_word = sel_b ? b_word    : a_word;
  assign y_word = sel_b ? a_word    : b_word;
  assign s_word = sel_b ? iS_sub_i2 : iS_sub_i1;

  // Shared logarithmic left rotator: stage i rotates by 2**i.
  logic [W-1:0] rot_stage [0:ROT_VALUE];
  assign rot_stage[0] = rot_in;

  for (genvar i = 0; i < ROT_VALUE; i++) begin : g_rot_stage
    localparam int SH = 1 << i;
    assign rot_stage[i+1] = rot_left_amt[i]
                          ? {rot_stage[i][W-1-SH:0], rot_stage[i][W-1:W-SH]}
                          : rot_stage[i];
  end

  assign rot_out = rot_stage[ROT_VALUE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_word      <= '0;
      b_word      <= '0;
      k           <= '0;
      oS_address1 <= T_LENGTH'(0);
      oS_address2 <= T_LENGTH'(1);
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
`ifdef RC5_DECRYPT_EN
      dec_mode    <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            a_word      <= iA;
            b_word      <= iB;
            k           <= k_start;
            oS_address1 <= {k_start, 1'b0};
            oS_address2 <= {k_start, 1'b1};
            oBusy       <= 1'b1;
            state       <= ST_ADDR;
`ifdef RC5_DECRYPT_EN
            dec_mode    <= iMode;
`endif
          end
        end
        ST_ADDR: state <= ST_WAIT;
        // The table RAM needs one extra cycle after the address registers.
        ST_WAIT: state <= ST_HALF1;
        ST_HALF1: begin
          if (sel_b) b_word <= half_result;
          else       a_word <= half_result;
          state <= ST_HALF2;
        end
        ST_HALF2: begin
          if (sel_b) b_word <= half_result;
          else       a_word <= half_result;
          if (k_last) begin
            oBusy <= 1'b0;
            oDone <= 1'b1;
            state <= ST_DONE;
          end else begin
            k           <= k_step;
            oS_address1 <= {k_step, 1'b0};
            oS_address2 <= {k_step, 1'b1};
            state       <= ST_ADDR;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oA = a_word;
  assign oB = b_word;

endmodule
`default_nettype wire

// File: tb/tb_rc5_crypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc5_crypt
// Purpose  : Directed self-checking bench for rc5_crypt. Two instances:
//            RC5-32/1 on an all-zero key table and RC5-32/12 on the table
//            expanded from an all-zero 16-byte key.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc5_crypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start12 = 1'b0;
  logic        mode_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  // RC5-32/1 instance, zero key table
  logic [1:0]  ad1_r1, ad2_r1;
  logic [31:0] s1_r1, s2_r1, oa_r1, ob_r1;
  logic        busy_r1, done_r1;

  // RC5-32/12 instance, zero-key expanded table
  logic [4:0]  ad1_r12, ad2_r12;
  logic [31:0] s1_r12, s2_r12, oa_r12, ob_r12;
  logic        busy_r12, done_r12;

  rc5_crypt #(.W(32), .R(1)) u_r1 (
    .clk(clk), .rst(rst), .iStart(start1), .iMode(mode_in),
    .iA(a_in), .iB(b_in),
    .oS_address1(ad1_r1), .oS_address2(ad2_r1),
    .iS_sub_i1(s1_r1), .iS_sub_i2(s2_r1),
    .oA(oa_r1), .oB(ob_r1), .oBusy(busy_r1), .oDone(done_r1)
  );

  rc5_crypt #(.W(32), .R(12)) u_r12 (
    .clk(clk), .rst(rst), .iStart(start12), .iMode(mode_in),
    .iA(a_in), .iB(b_in),
    .oS_address1(ad1_r12), .oS_address2(ad2_r12),
    .iS_sub_i1(s1_r12), .iS_sub_i2(s2_r12),
    .oA(oa_r12), .oB(ob_r12), .oBusy(busy_r12), .oDone(done_r12)
  );

  // Synchronous-read key tables
  logic [31:0] s_tab [0:25];
  always @(posedge clk) begin
    s1_r1  <= 32'h0;
    s2_r1  <= 32'h0;
    s1_r12 <= s_tab[ad1_r12];
    s2_r12 <= s_tab[ad2_r12];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] n);
    logic [63:0] d;
    d = {x, x} << n[4:0];
    return d[63:32];
  endfunction

  // Results of the last run_block call
  logic [31:0] res_a, res_b;
  logic [7:0]  ad1_c5, ad2_c5;
  int          done_cyc, busy_cyc;

  // Launches one block on the selected instance and waits (bounded) for oDone.
  // Returns with the DUT back in IDLE.
  task automatic run_block(input bit big, input logic mode, input logic [31:0] a, input logic [31:0] b);
    logic d, bz;
    a_in = a; b_in = b; mode_in = mode;
    done_cyc = -1; busy_cyc = 0;
    res_a = 'x; res_b = 'x; ad1_c5 = 'x; ad2_c5 = 'x;
    if (big) start12 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start12 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      d  = big ? done_r12 : done_r1;
      bz = big ? busy_r12 : busy_r1;
      if (c == 5) begin
        ad1_c5 = big ? {3'b0, ad1_r12} : {6'b0, ad1_r1};
        ad2_c5 = big ? {3'b0, ad2_r12} : {6'b0, ad2_r1};
      end
      if (bz) busy_cyc++;
      if (d) begin
        done_cyc = c;
        res_a = big ? oa_r12 : oa_r1;
        res_b = big ? ob_r12 : ob_r1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          ndone, dcyc;
  logic [31:0] ra, rb, pa, pb, ca, cb;

  initial begin
    // Key expansion for RC5-32/12 with a 16-byte all-zero key
    begin
      logic [31:0] kl [0:3];
      logic [31:0] ka, kb;
      int ki, kj;
      s_tab[0] = 32'hB7E1_5163;
      for (int i = 1; i < 26; i++) s_tab[i] = s_tab[i-1] + 32'h9E37_79B9;
      for (int i = 0; i < 4; i++) kl[i] = 32'h0;
      ka = 0; kb = 0; ki = 0; kj = 0;
      for (int n = 0; n < 78; n++) begin
        ka = rotl32(s_tab[ki] + ka + kb, 32'd3);
        s_tab[ki] = ka;
        kb = rotl32(kl[kj] + ka + kb, ka + kb);
        kl[kj] = kb;
        ki = (ki + 1) % 26;
        kj = (kj + 1) % 4;
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_oA", oa_r12, 32'h0);
    check("rst_oB", ob_r12, 32'h0);
    check("rst_addr1", ad1_r12, 5'd0);
    check("rst_addr2", ad2_r12, 5'd1);
    check("rst_busy", busy_r12, 1'b0);
    check("rst_done", done_r12, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // RC5-32/1, zero table
    run_block(1'b0, 1'b0, 32'h1, 32'h0);
    check("r1_a1_oA", res_a, 32'h0000_0001);
    check("r1_a1_oB", res_b, 32'h0000_0002);
    check("r1_done_cycle", done_cyc, 9);
    check("r1_busy_cycles", busy_cyc, 8);
    check("r1_addr1_k1", ad1_c5, 8'd2);
    check("r1_addr2_k1", ad2_c5, 8'd3);

    run_block(1'b0, 1'b0, 32'h8000_0000, 32'h1);
    check("r1_msb_oA", res_a, 32'h0000_0003);
    check("r1_msb_oB", res_b, 32'h0000_0010);

    // rotate amount taken from the low 5 bits only (0x78 -> 24)
    run_block(1'b0, 1'b0, 32'h1234_5678, 32'h0);
    check("r1_rot24_oA", res_a, 32'h1234_5678);
    check("r1_rot24_oB", res_b, 32'h7812_3456);

    // rotate amount 32 -> 0 (word unchanged), then 16
    run_block(1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0020);
    check("r1_rot0_oA", res_a, 32'h0000_00D0);
    check("r1_rot0_oB", res_b, 32'h00F0_0000);

    // RC5-32/12 zero-key known answer
    run_block(1'b1, 1'b0, 32'h0, 32'h0);
    check("r12_kat_oA", res_a, 32'hEEDB_A521);
    check("r12_kat_oB", res_b, 32'h6D8F_4B15);
    check("r12_done_cycle", done_cyc, 53);
    check("r12_busy_cycles", busy_cyc, 52);
    check("r12_addr1_k1", ad1_c5, 8'd2);
    check("r12_addr2_k1", ad2_c5, 8'd3);

`ifdef RC5_DECRYPT_EN
    run_block(1'b1, 1'b1, 32'hEEDB_A521, 32'h6D8F_4B15);
    check("r12_dec_oA", res_a, 32'h0);
    check("r12_dec_oB", res_b, 32'h0);
    check("r12_dec_done_cycle", done_cyc, 53);
    check("r12_dec_addr1_k11", ad1_c5, 8'd22);
    check("r12_dec_addr2_k11", ad2_c5, 8'd23);
    for (int t = 0; t < 6; t++) begin
      pa = $urandom; pb = $urandom;
      run_block(1'b1, 1'b0, pa, pb);
      ca = res_a; cb = res_b;
      run_block(1'b1, 1'b1, ca, cb);
      check("r12_roundtrip_A", res_a, pa);
      check("r12_roundtrip_B", res_b, pb);
    end
`else
    // iMode is ignored: still encrypts
    run_block(1'b1, 1'b1, 32'h0, 32'h0);
    check("r12_mode1_enc_oA", res_a, 32'hEEDB_A521);
    check("r12_mode1_enc_oB", res_b, 32'h6D8F_4B15);
`endif

    // Start held for 10 cycles, plus a second pulse at cycle 20
    a_in = 32'h0; b_in = 32'h0; mode_in = 1'b0;
    start12 = 1'b1;
    @(posedge clk); #1;
    ndone = 0; dcyc = -1; ra = 'x; rb = 'x;
    for (int c = 1; c <= 120; c++) begin
      if (c == 10) start12 = 1'b0;
      if (c == 20) begin start12 = 1'b1; a_in = 32'hFFFF_FFFF; end
      if (c == 21) begin start12 = 1'b0; a_in = 32'h0; end
      if (done_r12) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; ra = oa_r12; rb = ob_r12; end
      end
      @(posedge clk); #1;
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_done_cycle", dcyc, 53);
    check("busy_start_oA", ra, 32'hEEDB_A521);
    check("busy_start_oB", rb, 32'h6D8F_4B15);

    // Reset in cycle 30 of an operation
    a_in = 32'h0; b_in = 32'h0; mode_in = 1'b0;
    start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    for (int c = 1; c < 30; c++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", busy_r12, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy_r12, 1'b0);
    check("mid_rst_oA", oa_r12, 32'h0);
    check("mid_rst_oB", ob_r12, 32'h0);
    check("mid_rst_addr1", ad1_r12, 5'd0);
    check("mid_rst_addr2", ad2_r12, 5'd1);
    check("mid_rst_done", done_r12, 1'b0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_r12 || busy_r12) ndone++;
      @(posedge clk); #1;
    end
    check("post_rst_idle", ndone, 0);

    run_block(1'b1, 1'b0, 32'h0, 32'h0);
    check("post_rst_oA", res_a, 32'hEEDB_A521);
    check("post_rst_oB", res_b, 32'h6D8F_4B15);
    check("post_rst_done_cycle", done_cyc, 53);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
